cmd_frame_decoder: RTL and testbench
====================================

CMD_FRAME_DECODER -- requirements
Module: cmd_frame_decoder

Interface
REQ-001 SHALL have parameters: DW, default 8, byte width; AW, default 4, register-file address width; TIMEOUT_CYC, default 1000, inter-byte timeout in clk cycles (1..65535).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock, the destination domain of the synchronized UART RX data.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  DW  synchronized received byte.
- rx_valid  in  1  one-cycle pulse, rx_data valid.
- rf_rd_valid  in  1  register-file read data valid.
- alu_out_valid  in  1  ALU result valid.
- rf_wr_en  out  1  register-file write strobe.
- rf_rd_en  out  1  register-file read strobe.
- rf_addr  out  AW  register-file address.
- rf_wr_data  out  DW  register-file write data.
- alu_en  out  1  ALU start strobe.
- alu_fun  out  4  ALU function code.
- clk_gate_en  out  1  ALU clock-gate enable.
- cmd_done  out  1  one-cycle command-complete pulse.
- cmd_err  out  1  one-cycle protocol-error pulse.

Function
REQ-003 SHALL register all outputs; strobes rf_wr_en, rf_rd_en, alu_en, cmd_done and cmd_err are one cycle wide.
REQ-004 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN, WAIT_RD and WAIT_ALU, and SHALL act on rx_data only in a cycle where rx_valid=1.
REQ-005 SHALL decode the command byte in IDLE as follows:
- 0xAA goes to WR_ADDR.
- 0xBB goes to RD_ADDR.
- 0xCC goes to OPA.
- 0xDD goes to FUN.
- Any other byte pulses cmd_err and remains in IDLE.
REQ-006 Register write: the WR_ADDR byte SHALL latch rf_addr=rx_data[AW-1:0]. The WR_DATA byte SHALL assert rf_wr_en with rf_wr_data=rx_data in the next cycle, then pulse cmd_done together with rf_wr_en and return to IDLE.
REQ-007 Register read: the RD_ADDR byte SHALL assert rf_rd_en with rf_addr set in the next cycle and go to WAIT_RD. WAIT_RD SHALL pulse cmd_done and go to IDLE in the cycle after rf_rd_valid=1.
REQ-008 Operand A: the OPA byte SHALL produce an rf_wr_en write to address 0 in the next cycle and go to OPB.
REQ-009 Operand B: the OPB byte SHALL produce an rf_wr_en write to address 1 in the next cycle and go to FUN.
REQ-010 The FUN byte SHALL assert alu_en with alu_fun=rx_data[3:0] in the next cycle and go to WAIT_ALU.
REQ-011 clk_gate_en SHALL be 1 from the cycle alu_en asserts until the cycle after alu_out_valid=1 is sampled in WAIT_ALU; cmd_done SHALL pulse in that same cycle, and the state SHALL return to IDLE.
REQ-012 rx_valid in WAIT_RD or WAIT_ALU SHALL discard the byte, pulse cmd_err and leave the state unchanged, including when it coincides with completion.
REQ-013 rf_addr, rf_wr_data and alu_fun SHALL hold their last values when not strobed.
REQ-014 rf_rd_valid and alu_out_valid SHALL be ignored outside WAIT_RD and WAIT_ALU.

Reset
REQ-015 While rst=1, asynchronously: state SHALL be IDLE, all outputs 0 and the timeout counter 0.
REQ-016 Reset mid-frame SHALL abandon the frame with no strobe issued.
REQ-017 The first rx_valid after reset release SHALL be decoded as a command byte.

Configuration
REQ-018 With macro CMD_TIMEOUT_EN defined, a 16-bit counter SHALL run in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN, and SHALL clear on rx_valid and on each state entry.
REQ-019 With CMD_TIMEOUT_EN defined, TIMEOUT_CYC consecutive cycles without rx_valid in those states SHALL pulse cmd_err and return to IDLE with no strobe.
REQ-020 Without CMD_TIMEOUT_EN, no counter SHALL exist and those states SHALL wait indefinitely; ports are identical in both builds.

Verification
REQ-021 Bytes AA,05,3C -> one cycle of rf_wr_en=1, rf_addr=5, rf_wr_data=0x3C, cmd_done=1.
REQ-022 Bytes BB,07, then rf_rd_valid 4 cycles later -> rf_rd_en=1 with rf_addr=7, then cmd_done=1 one cycle after rf_rd_valid.
REQ-023 Bytes CC,12,34,02 with alu_out_valid 3 cycles after alu_en:
- rf_wr_en writes 0x12 to address 0, then 0x34 to address 1.
- alu_en=1 with alu_fun=2.
- clk_gate_en=1 until cmd_done.
REQ-024 Byte 0x55 in IDLE, and a byte during WAIT_ALU -> cmd_err pulse each time, no state change.
REQ-025 Reset mid-frame after AA,05:
- rst pulse -> all outputs 0 and no rf_wr_en.
- Subsequent DD,01 -> alu_en=1 with alu_fun=1.
REQ-026 With CMD_TIMEOUT_EN and TIMEOUT_CYC=10, byte AA then silence -> cmd_err pulse 10 cycles later and return to IDLE. Without the macro, no cmd_err.

Source files
------------

// File: rtl/cmd_frame_decoder.sv
// rtl/cmd_frame_decoder.sv - UART command frame decoder driving register file and ALU strobes (optional CMD_TIMEOUT_EN)
module cmd_frame_decoder #(
   parameter int DW          = 8,
   parameter int AW          = 4,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_valid,
   input  logic          rf_rd_valid,
   input  logic          alu_out_valid,
   output logic          rf_wr_en,
   output logic          rf_rd_en,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_wr_data,
   output logic          alu_en,
   output logic [3:0]    alu_fun,
   output logic          clk_gate_en,
   output logic          cmd_done,
   output logic          cmd_err
);

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      OPA,
      OPB,
      FUN,
      WAIT_RD,
      WAIT_ALU
   } state_t;

   localparam logic [DW-1:0] CMD_WR  = DW'('hAA);
   localparam logic [DW-1:0] CMD_RD  = DW'('hBB);
   localparam logic [DW-1:0] CMD_OPS = DW'('hCC);
   localparam logic [DW-1:0] CMD_FUN = DW'('hDD);

   state_t        state_q, state_d;
   logic          rf_wr_en_q, rf_wr_en_d;
   logic          rf_rd_en_q, rf_rd_en_d;
   logic [AW-1:0] rf_addr_q, rf_addr_d;
   logic [DW-1:0] rf_wr_data_q, rf_wr_data_d;
   logic          alu_en_q, alu_en_d;
   logic [3:0]    alu_fun_q, alu_fun_d;
   logic          clk_gate_en_q, clk_gate_en_d;
   logic          cmd_done_q, cmd_done_d;
   logic          cmd_err_q, cmd_err_d;

`ifdef CMD_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        in_frame;
`endif

   // Next-state and registered-output computation; payload fields hold unless strobed
   always_comb begin
      state_d       = state_q;
      rf_wr_en_d    = 1'b0;
      rf_rd_en_d    = 1'b0;
      rf_addr_d     = rf_addr_q;
      rf_wr_data_d  = rf_wr_data_q;
      alu_en_d      = 1'b0;
      alu_fun_d     = alu_fun_q;
      clk_gate_en_d = 1'b0;
      cmd_done_d    = 1'b0;
      cmd_err_d     = 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_cnt_d      = '0;
      in_frame      = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_WR)       state_d = WR_ADDR;
               else if (rx_data == CMD_RD)  state_d = RD_ADDR;
               else if (rx_data == CMD_OPS) state_d = OPA;
               else if (rx_data == CMD_FUN) state_d = FUN;
               else                         cmd_err_d = 1'b1;
            end
         end
         WR_ADDR: begin
            if (rx_valid) begin
               rf_addr_d = rx_data[AW-1:0];
               state_d   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (rx_valid) begin
               rf_wr_en_d   = 1'b1;
               rf_wr_data_d = rx_data;
               cmd_done_d   = 1'b1;
               state_d      = IDLE;
            end
         end
         RD_ADDR: begin
            if (rx_valid) begin
               rf_rd_en_d = 1'b1;
               rf_addr_d  = rx_data[AW-1:0];
               state_d    = WAIT_RD;
            end
         end
         OPA: begin
            if (rx_valid) begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = '0;
               rf_wr_data_d = rx_data;
               state_d      = OPB;
            end
         end
         OPB: begin
            if (rx_valid) begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = AW'(1);
               rf_wr_data_d = rx_data;
               state_d      = FUN;
            end
         end
         FUN: begin
            if (rx_valid) begin
               alu_en_d      = 1'b1;
               alu_fun_d     = rx_data[3:0];
               clk_gate_en_d = 1'b1;
               state_d       = WAIT_ALU;
            end
         end
         WAIT_RD: begin
            // A stray byte wins over completion: frame stays open
            if (rx_valid) begin
               cmd_err_d = 1'b1;
            end else if (rf_rd_valid) begin
               cmd_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
         WAIT_ALU: begin
            // Gate stays open through the completion cycle
            clk_gate_en_d = 1'b1;
            if (rx_valid) begin
               cmd_err_d = 1'b1;
            end else if (alu_out_valid) begin
               cmd_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef CMD_TIMEOUT_EN
      in_frame = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                 (state_q == OPA) || (state_q == OPB) || (state_q == FUN);
      // Silence in a byte-collecting state: count, and abandon the frame when it expires
      if (in_frame && !rx_valid) begin
         if (to_cnt_q == TO_LAST) begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
         end else begin
            to_cnt_d = to_cnt_q + 16'd1;
         end
      end
`endif
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         rf_addr_q     <= '0;
         rf_wr_data_q  <= '0;
         alu_en_q      <= 1'b0;
         alu_fun_q     <= '0;
         clk_gate_en_q <= 1'b0;
         cmd_done_q    <= 1'b0;
         cmd_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rf_wr_en_q    <= rf_wr_en_d;
         rf_rd_en_q    <= rf_rd_en_d;
         rf_addr_q     <= rf_addr_d;
         rf_wr_data_q  <= rf_wr_data_d;
         alu_en_q      <= alu_en_d;
         alu_fun_q     <= alu_fun_d;
         clk_gate_en_q <= clk_gate_en_d;
         cmd_done_q    <= cmd_done_d;
         cmd_err_q     <= cmd_err_d;
      end
   end

`ifdef CMD_TIMEOUT_EN
   // Inter-byte silence counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`endif

   assign rf_wr_en    = rf_wr_en_q;
   assign rf_rd_en    = rf_rd_en_q;
   assign rf_addr     = rf_addr_q;
   assign rf_wr_data  = rf_wr_data_q;
   assign alu_en      = alu_en_q;
   assign alu_fun     = alu_fun_q;
   assign clk_gate_en = clk_gate_en_q;
   assign cmd_done    = cmd_done_q;
   assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb/tb_cmd_frame_decoder.sv - self-checking bench for cmd_frame_decoder (honours CMD_TIMEOUT_EN)
module tb_cmd_frame_decoder;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rf_rd_valid = 1'b0;
   logic          alu_out_valid = 1'b0;
   logic          rf_wr_en, rf_rd_en, alu_en, clk_gate_en, cmd_done, cmd_err;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wr_data;
   logic [3:0]    alu_fun;

   int n_cmp = 0;
   int n_err = 0;

   cmd_frame_decoder #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rf_rd_valid(rf_rd_valid), .alu_out_valid(alu_out_valid),
      .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
      .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
      .clk_gate_en(clk_gate_en), .cmd_done(cmd_done), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level reference: bytes of the open frame, plus which completion is awaited
   logic [7:0]    frame[$];
   int            wait_kind = 0;     // 0 none, 1 read data, 2 alu result
   int            silence = 0;
   logic          e_wr, e_rd, e_alu, e_gate, e_done, e_err;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;
   logic [3:0]    e_fun;

   always @(posedge clk or posedge rst) begin
      logic [7:0] c, b;
      if (rst) begin
         frame.delete();
         wait_kind = 0; silence = 0;
         e_wr = 0; e_rd = 0; e_alu = 0; e_gate = 0; e_done = 0; e_err = 0;
         e_addr = '0; e_wdata = '0; e_fun = '0;
      end else begin
         e_wr = 0; e_rd = 0; e_alu = 0; e_gate = 0; e_done = 0; e_err = 0;
         if (wait_kind != 0) begin
            e_gate = (wait_kind == 2);
            if (rx_valid) e_err = 1;
            else if ((wait_kind == 1 && rf_rd_valid) || (wait_kind == 2 && alu_out_valid)) begin
               e_done = 1;
               wait_kind = 0;
            end
         end else if (rx_valid) begin
            frame.push_back(rx_data);
            silence = 0;
            c = frame[0];
            b = frame[frame.size() - 1];
            if (frame.size() == 1) begin
               if (!(c inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) begin
                  e_err = 1;
                  frame.delete();
               end
            end else if (c == 8'hAA) begin
               if (frame.size() == 2) e_addr = b[AW-1:0];
               else begin
                  e_wr = 1; e_wdata = b; e_done = 1; frame.delete();
               end
            end else if (c == 8'hBB) begin
               e_rd = 1; e_addr = b[AW-1:0]; wait_kind = 1; frame.delete();
            end else if (c == 8'hCC && frame.size() < 4) begin
               e_wr = 1; e_wdata = b; e_addr = AW'(frame.size() - 2);
            end else begin
               e_alu = 1; e_fun = b[3:0]; e_gate = 1; wait_kind = 2; frame.delete();
            end
         end else if (frame.size() > 0) begin
`ifdef CMD_TIMEOUT_EN
            silence++;
            if (silence == TO) begin
               e_err = 1; silence = 0; frame.delete();
            end
`endif
         end
      end
   end

   // Cycle-by-cycle comparison against the reference
   always @(negedge clk) begin
      chk("rf_wr_en", rf_wr_en, e_wr);
      chk("rf_rd_en", rf_rd_en, e_rd);
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_wr_data", rf_wr_data, e_wdata);
      chk("alu_en", alu_en, e_alu);
      chk("alu_fun", alu_fun, e_fun);
      chk("clk_gate_en", clk_gate_en, e_gate);
      chk("cmd_done", cmd_done, e_done);
      chk("cmd_err", cmd_err, e_err);
   end

   task automatic send(input logic [7:0] b);
      rx_data = b; rx_valid = 1;
      @(negedge clk);
      rx_valid = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rd();
      rf_rd_valid = 1; @(negedge clk); rf_rd_valid = 0;
   endtask

   task automatic pulse_alu();
      alu_out_valid = 1; @(negedge clk); alu_out_valid = 0;
   endtask

   int errs_seen;

   initial begin
      idle(3);
      chk("reset outputs", {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                            clk_gate_en, cmd_done, cmd_err}, 0);
      rst = 0;
      idle(1);

      // register write
      send(8'hAA); send(8'h05); send(8'h3C);
      chk("wr strobe", {rf_wr_en, cmd_done, rf_addr, rf_wr_data}, {1'b1, 1'b1, 4'h5, 8'h3C});
      idle(1);
      chk("wr one cycle", {rf_wr_en, cmd_done}, 0);

      // register read
      send(8'hBB); send(8'h07);
      chk("rd strobe", {rf_rd_en, rf_addr}, {1'b1, 4'h7});
      idle(3);
      chk("rd waiting", cmd_done, 0);
      pulse_rd();
      chk("rd done", cmd_done, 1);

      // operands + function
      send(8'hCC); send(8'h12);
      chk("opa write", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h0, 8'h12});
      send(8'h34);
      chk("opb write", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h1, 8'h34});
      send(8'h02);
      chk("alu start", {alu_en, alu_fun, clk_gate_en}, {1'b1, 4'h2, 1'b1});
      idle(2);
      chk("gate held", {alu_en, clk_gate_en}, {1'b0, 1'b1});
      pulse_alu();
      chk("alu done", cmd_done, 1);
      idle(1);
      chk("gate closed", {clk_gate_en, cmd_done}, 0);

      // protocol errors
      send(8'h55);
      chk("bad cmd err", cmd_err, 1);
      pulse_alu();
      chk("alu valid ignored in idle", {cmd_done, cmd_err}, 0);
      send(8'hDD); send(8'h03);
      send(8'h77);
      chk("byte in wait_alu", {cmd_err, clk_gate_en, cmd_done}, {1'b1, 1'b1, 1'b0});
      pulse_alu();
      chk("alu done after err", cmd_done, 1);

      // stray byte coinciding with read completion
      send(8'hBB); send(8'h02);
      rf_rd_valid = 1; send(8'h11); rf_rd_valid = 0;
      chk("coincident err", {cmd_err, cmd_done}, {1'b1, 1'b0});
      pulse_rd();
      chk("rd done after err", cmd_done, 1);

      // reset mid-frame
      send(8'hAA); send(8'h05);
      @(posedge clk); #2 rst = 1; #1;
      chk("async reset", {rf_wr_en, rf_addr, rf_wr_data, cmd_done, cmd_err, clk_gate_en}, 0);
      @(negedge clk); rst = 0;
      idle(2);
      send(8'hDD); send(8'h01);
      chk("alu after reset", {alu_en, alu_fun}, {1'b1, 4'h1});
      pulse_alu();

      // inter-byte silence
      send(8'hAA);
      errs_seen = 0;
      for (int i = 0; i < TO + 3; i++) begin
         @(negedge clk);
         if (cmd_err) errs_seen++;
      end
`ifdef CMD_TIMEOUT_EN
      chk("timeout err count", errs_seen, 1);
`else
      chk("no timeout err", errs_seen, 0);
`endif
      @(negedge clk); rst = 1; @(negedge clk); rst = 0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst = 1; @(negedge clk); rst = 0;
         end
         rx_valid      = ($urandom_range(0, 3) == 0);
         rx_data       = ($urandom_range(0, 9) < 5) ? 8'hAA + 8'(8'h11 * $urandom_range(0, 3))
                                                     : 8'($urandom);
         rf_rd_valid   = ($urandom_range(0, 4) == 0);
         alu_out_valid = ($urandom_range(0, 4) == 0);
         @(negedge clk);
      end
      rx_valid = 0; rf_rd_valid = 0; alu_out_valid = 0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
